// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants and the nibble-to-segment decode function
// for the seven-segment scan driver. Segments are active low, ordered g..a
// (bit6 = g, bit0 = a).
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // Letters A-F only render when hex_en is set; otherwise they show blank.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble, input logic hex_en);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = hex_en ? GLYPH_A : SEG_BLANK;
      4'hB:    seg = hex_en ? GLYPH_B : SEG_BLANK;
      4'hC:    seg = hex_en ? GLYPH_C : SEG_BLANK;
      4'hD:    seg = hex_en ? GLYPH_D : SEG_BLANK;
      4'hE:    seg = hex_en ? GLYPH_E : SEG_BLANK;
      4'hF:    seg = hex_en ? GLYPH_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_hex_decoder.sv
// seven_segment_hex_decoder: combinational nibble -> active-low segment pattern.
// Ports:
//   nibble   in  4  digit value 0-F
//   hex_en   in  1  1 = show A-F glyphs, 0 = show A-F as blank
//   segment  out 7  active-low segments g..a
module seven_segment_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] segment
);

  // Glyph lookup.
  always_comb begin
    segment = seg7_decode(nibble, hex_en);
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// seven_segment_scan_driver: time-multiplexed driver for an N-digit
// common-anode 7-segment display. New data is staged in shadow registers and
// only committed at a frame boundary, so a frame never mixes old and new data.
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   load         1-cycle strobe capturing value/dp_in/blank_in/hex_en/lz_suppress
//   value        packed nibbles, nibble i = digit i (digit 0 rightmost)
//   dp_in        per-digit decimal point enable (1 = lit)
//   blank_in     per-digit force-blank
//   hex_en       show A-F as glyphs
//   lz_suppress  blank leading zeros (digit 0 always shown)
//   segment, dp  registered active-low segment / decimal-point pins
//   anode        registered one-hot digit enable (polarity per ANODE_ACTIVE_LOW)
//   frame_done   registered 1-cycle pulse after the last slot of a frame
module seven_segment_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    hex_en,
  input  logic                    lz_suppress,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIMIT = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] INDEX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           prescaler;
  logic [IW-1:0]           index;

  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;
  logic                    shadow_hex;
  logic                    shadow_lz;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] commit_value;
  logic [NUM_DIGITS-1:0]   commit_dp;
  logic [NUM_DIGITS-1:0]   commit_blank;
  logic                    commit_hex;
  logic                    commit_lz;

  logic                    slot_end;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_above;
  logic [3:0]              cur_nibble;
  logic [6:0]              dec_segment;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [6:0]              segment_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   anode_next;

  assign slot_end = (prescaler == PRESC_LAST);
  assign boundary = slot_end && (index == INDEX_LAST);

  // Prescaler and digit index counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      index     <= '0;
    end else if (slot_end) begin
      prescaler <= '0;
      index     <= (index == INDEX_LAST) ? '0 : index + IW'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Shadow capture on load; pending marks shadow data not yet committed.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      shadow_hex   <= 1'b0;
      shadow_lz    <= 1'b0;
      pending      <= 1'b0;
    end else begin
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
        shadow_hex   <= hex_en;
        shadow_lz    <= lz_suppress;
      end
      // A load landing on the boundary is committed directly, so it never pends.
      if (boundary) begin
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Frame-boundary commit; the live inputs bypass the shadow on a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_value <= '0;
      commit_dp    <= '0;
      commit_blank <= '0;
      commit_hex   <= 1'b0;
      commit_lz    <= 1'b0;
    end else if (boundary && load) begin
      commit_value <= value;
      commit_dp    <= dp_in;
      commit_blank <= blank_in;
      commit_hex   <= hex_en;
      commit_lz    <= lz_suppress;
    end else if (boundary && pending) begin
      commit_value <= shadow_value;
      commit_dp    <= shadow_dp;
      commit_blank <= shadow_blank;
      commit_hex   <= shadow_hex;
      commit_lz    <= shadow_lz;
    end
  end

  // Leading-zero mask: digit i is suppressed when it and every digit above it are zero.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (commit_value[i*4 +: 4] == 4'h0);
      lz_mask[i] = commit_lz & zero_above;
    end
  end

  assign cur_nibble = commit_value[index*4 +: 4];

  seven_segment_hex_decoder u_decoder (
    .nibble  (cur_nibble),
    .hex_en  (commit_hex),
    .segment (dec_segment)
  );

  // Next pin values for the current slot position.
  always_comb begin
    onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << index;
    if (prescaler < BLANK_LIMIT) begin
      segment_next = SEG_BLANK;
      dp_next      = 1'b1;
      anode_next   = ANODE_OFF;
    end else begin
      segment_next = (commit_blank[index] || lz_mask[index]) ? SEG_BLANK : dec_segment;
      dp_next      = ~commit_dp[index];
      anode_next   = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  // Output pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      segment    <= SEG_BLANK;
      dp         <= 1'b1;
      anode      <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      segment    <= segment_next;
      dp         <= dp_next;
      anode      <= anode_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Testbench for seven_segment_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYCLES=1, active-low anodes. A frame is 16 cycles; each slot opens
// with one all-off cycle followed by three cycles of the digit.
module tb_seven_segment_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        hex_en;
  logic        lz_suppress;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(
    .NUM_DIGITS       (4),
    .REFRESH_DIV      (4),
    .BLANK_CYCLES     (1),
    .ANODE_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .hex_en      (hex_en),
    .lz_suppress (lz_suppress),
    .segment     (segment),
    .dp          (dp),
    .anode       (anode),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            hex;
    logic            lz;
    logic [3:0][6:0] es;   // expected segment per digit {d3,d2,d1,d0}
    logic [3:0]      edp;  // expected dp pin per digit
  } vec_t;

  vec_t vecs[9];
  logic [3:0] an_on[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, " anode"}, {12'h000, anode}, 16'h000F);
    check({tag, " seg"}, {9'h000, segment}, 16'h007F);
    check({tag, " dp"}, {15'h0000, dp}, 16'h0001);
    check({tag, " frame_done"}, {15'h0000, frame_done}, 16'h0000);
  endtask

  // Runs one 16-cycle frame starting right after a frame start, optionally
  // strobing loads before steps lk1/lk2, and checks every sampled cycle.
  task automatic capture_frame(input string tag, input int lk1, input logic [15:0] lv1,
                               input int lk2, input logic [15:0] lv2,
                               input logic [3:0][6:0] es, input logic [3:0] edp);
    int slot;
    int ph;
    for (int k = 1; k <= 16; k++) begin
      if (k == lk1) begin
        value = lv1;
        load  = 1'b1;
      end else if (k == lk2) begin
        value = lv2;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      step();
      load = 1'b0;
      slot = (k - 1) / 4;
      ph   = (k - 1) % 4;
      if (ph == 0) begin
        check($sformatf("%s s%0d blank anode", tag, slot), {12'h000, anode}, 16'h000F);
        check($sformatf("%s s%0d blank seg", tag, slot), {9'h000, segment}, 16'h007F);
        check($sformatf("%s s%0d blank dp", tag, slot), {15'h0000, dp}, 16'h0001);
      end else begin
        check($sformatf("%s s%0d p%0d anode", tag, slot, ph), {12'h000, anode},
              {12'h000, an_on[slot]});
        check($sformatf("%s s%0d p%0d seg", tag, slot, ph), {9'h000, segment},
              {9'h000, es[slot]});
        check($sformatf("%s s%0d p%0d dp", tag, slot, ph), {15'h0000, dp},
              {15'h0000, edp[slot]});
      end
      check($sformatf("%s k%0d frame_done", tag, k), {15'h0000, frame_done},
            (k == 16) ? 16'h0001 : 16'h0000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][6:0] prev_es;
    logic [3:0]      prev_edp;

    an_on[0] = 4'b1110;
    an_on[1] = 4'b1101;
    an_on[2] = 4'b1011;
    an_on[3] = 4'b0111;

    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'hABCD, 4'b0000, 4'b0000, 1'b1, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
    vecs[2] = '{16'hABCD, 4'b0000, 4'b0000, 1'b0, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
    vecs[3] = '{16'h0005, 4'b0000, 4'b0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111};
    vecs[4] = '{16'h0000, 4'b0100, 4'b0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011};
    vecs[5] = '{16'h0105, 4'b0000, 4'b0000, 1'b0, 1'b1, {7'h7F, 7'h79, 7'h40, 7'h12}, 4'b1111};
    vecs[6] = '{16'h8888, 4'b0010, 4'b0010, 1'b0, 1'b0, {7'h00, 7'h00, 7'h7F, 7'h00}, 4'b1101};
    vecs[7] = '{16'h9A76, 4'b1001, 4'b0000, 1'b0, 1'b0, {7'h10, 7'h7F, 7'h78, 7'h02}, 4'b0110};
    vecs[8] = '{16'hEF00, 4'b0000, 4'b0000, 1'b1, 1'b1, {7'h06, 7'h0E, 7'h40, 7'h40}, 4'b1111};

    rst         = 1'b1;
    load        = 1'b0;
    value       = 16'h0000;
    dp_in       = 4'b0000;
    blank_in    = 4'b0000;
    hex_en      = 1'b0;
    lz_suppress = 1'b0;

    repeat (3) step();
    check_reset_pins("reset");
    rst = 1'b0;

    prev_es  = {7'h40, 7'h40, 7'h40, 7'h40};
    prev_edp = 4'b1111;
    capture_frame("post_reset", 0, 16'h0000, 0, 16'h0000, prev_es, prev_edp);

    // Each vector: load early in a frame (that frame keeps old data), then check the next frame.
    for (int i = 0; i < 9; i++) begin
      dp_in       = vecs[i].dp;
      blank_in    = vecs[i].blank;
      hex_en      = vecs[i].hex;
      lz_suppress = vecs[i].lz;
      capture_frame($sformatf("v%0d_old", i), 2, vecs[i].value, 0, 16'h0000, prev_es, prev_edp);
      capture_frame($sformatf("v%0d_new", i), 0, 16'h0000, 0, 16'h0000, vecs[i].es, vecs[i].edp);
      prev_es  = vecs[i].es;
      prev_edp = vecs[i].edp;
    end

    // Two loads in one frame: current frame untouched, last load wins next frame.
    dp_in       = 4'b0000;
    blank_in    = 4'b0000;
    hex_en      = 1'b0;
    lz_suppress = 1'b0;
    capture_frame("multi_cur", 6, 16'h1111, 10, 16'h2222, prev_es, prev_edp);
    capture_frame("multi_next", 0, 16'h0000, 0, 16'h0000,
                  {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

    // Load on the boundary cycle shows in the very next frame.
    capture_frame("bypass_cur", 16, 16'h3333, 0, 16'h0000,
                  {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);
    capture_frame("bypass_next", 0, 16'h0000, 0, 16'h0000,
                  {7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111);

    // Reset mid-frame (slot 2) with a pending load: load is discarded.
    value = 16'h4444;
    load  = 1'b1;
    step();
    load = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    step();
    check_reset_pins("midrst");
    rst = 1'b0;
    capture_frame("rst_restart", 0, 16'h0000, 0, 16'h0000,
                  {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
    capture_frame("rst_discard", 0, 16'h0000, 0, 16'h0000,
                  {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
